// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - fetch/load-store arbiter for one shared memory bus port with watchdog.
// Optional round-robin grant on contention: define LETC_MEM_ARB_ROUND_ROBIN_EN.
module core_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        i_rsp_valid,
    output logic        i_rsp_error,
    output logic [31:0] i_rsp_rdata,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_we,
    input  logic [31:0] d_req_wdata,
    input  logic [3:0]  d_req_wmask,
    output logic        d_rsp_valid,
    output logic        d_rsp_error,
    output logic [31:0] d_rsp_rdata,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata,
    output logic        timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    localparam bit                   TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    state_e                 state_ff, state_d;
    logic [31:0]            addr_q, addr_d;
    logic                   we_q, we_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wmask_q, wmask_d;
    logic                   owner_q, owner_d;   // 1 = D port owns the transaction
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;

    logic any_req;
    logic grant_d_port;
    logic expire;
    logic rsp_fire;
    logic rsp_err;

    assign any_req = rst_n && (i_req_valid || d_req_valid);

`ifdef LETC_MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // On contention favour whichever port lost the previous grant.
    always_comb begin
        if (d_req_valid && i_req_valid) begin
            grant_d_port = ~last_grant_q;
        end else begin
            grant_d_port = d_req_valid;
        end
    end
`else
    assign grant_d_port = d_req_valid;
`endif

    always_comb begin
        state_d       = state_ff;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
`ifdef LETC_MEM_ARB_ROUND_ROBIN_EN
        last_grant_d  = last_grant_q;
`endif
        i_req_ready   = 1'b0;
        d_req_ready   = 1'b0;
        bus_req_valid = 1'b0;
        bus_addr      = 32'h0;
        bus_we        = 1'b0;
        bus_wdata     = 32'h0;
        bus_wmask     = 4'h0;
        timeout_pulse = 1'b0;
        rsp_fire      = 1'b0;
        rsp_err       = 1'b0;
        expire        = TO_EN && (cnt_q == TO_LAST);

        case (state_ff)
            IDLE: begin
                if (any_req) begin
                    d_req_ready = grant_d_port;
                    i_req_ready = ~grant_d_port;
                    owner_d     = grant_d_port;
                    cnt_d       = '0;
                    state_d     = ISSUE;
`ifdef LETC_MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_d_port;
`endif
                    if (grant_d_port) begin
                        addr_d  = d_req_addr;
                        we_d    = d_req_we;
                        wdata_d = d_req_wdata;
                        wmask_d = d_req_wmask;
                    end else begin
                        addr_d  = i_req_addr;
                        we_d    = 1'b0;
                        wdata_d = 32'h0;
                        wmask_d = 4'hF;
                    end
                end
            end
            ISSUE: begin
                bus_req_valid = 1'b1;
                bus_addr      = addr_q;
                bus_we        = we_q;
                bus_wdata     = wdata_q;
                bus_wmask     = wmask_q;
                cnt_d         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TIMEOUT_W'(1);
                // Responses cannot legally arrive before acceptance, so only expiry matters here.
                if (expire) begin
                    timeout_pulse = 1'b1;
                    rsp_fire      = 1'b1;
                    rsp_err       = 1'b1;
                    state_d       = IDLE;
                end else if (bus_req_ready) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TIMEOUT_W'(1);
                if (bus_rsp_valid) begin
                    rsp_fire = 1'b1;
                    state_d  = IDLE;
                end else if (expire) begin
                    timeout_pulse = 1'b1;
                    rsp_fire      = 1'b1;
                    rsp_err       = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        i_rsp_valid = rsp_fire && !owner_q;
        i_rsp_error = rsp_fire && rsp_err && !owner_q;
        i_rsp_rdata = (rsp_fire && !rsp_err && !owner_q) ? bus_rdata : 32'h0;
        d_rsp_valid = rsp_fire && owner_q;
        d_rsp_error = rsp_fire && rsp_err && owner_q;
        d_rsp_rdata = (rsp_fire && !rsp_err && owner_q) ? bus_rdata : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_ff <= IDLE;
            addr_q   <= 32'h0;
            we_q     <= 1'b0;
            wdata_q  <= 32'h0;
            wmask_q  <= 4'h0;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_ff <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef LETC_MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

endmodule
